// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the goal-game controller: FSM state encoding, the
// four sound codes sent to the audio block, and the sound priority function
// used to decide whether a new sound request may replace the active one.
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INTRO = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] SND_OFF   = 4'b0000;
  localparam logic [3:0] SND_START = 4'b1010;
  localparam logic [3:0] SND_GOAL  = 4'b1111;
  localparam logic [3:0] SND_END   = 4'b1100;

  // Priority rank of a sound code: END > GOAL > START > OFF.
  function automatic logic [1:0] snd_prio(input logic [3:0] code);
    logic [1:0] p;
    case (code)
      SND_END:   p = 2'd3;
      SND_GOAL:  p = 2'd2;
      SND_START: p = 2'd1;
      default:   p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// -----------------------------------------------------------------------------
// sensor_debounce
// Falling-edge detector with re-arm filter for the (already synchronised)
// active-low ball sensor. A 1-cycle hit is produced when the input goes low
// while armed; the detector then disarms and re-arms only after the input has
// been high for DEB_CYC consecutive cycles, so chatter yields a single hit.
// Ports:
//   CLOCK_50 : clock
//   Clr      : asynchronous active-low reset (leaves the detector disarmed)
//   in       : synchronised sensor level (idle high)
//   hit      : registered 1-cycle hit pulse
// -----------------------------------------------------------------------------
module sensor_debounce
  import game_pkg::*;
#(
  parameter int DEB_CYC = 500000
) (
  input  logic CLOCK_50,
  input  logic Clr,
  input  logic in,
  output logic hit
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic          r_hit;

  // Arm/disarm tracking, stable-high counter and hit pulse generation.
  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      r_armed <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_hit   <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      if (r_armed) begin
        if (!in) begin
          r_hit   <= 1'b1;
          r_armed <= 1'b0;
        end
      end else if (in) begin
        if (r_cnt == CNT_MAX) begin
          r_armed <= 1'b1;
          r_cnt   <= {CW{1'b0}};
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // any low sample restarts the stable-high window
        r_cnt <= {CW{1'b0}};
      end
    end
  end

  assign hit = r_hit;

endmodule

// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
// Round controller for a timed goal game: IDLE -> INTRO (start sound) ->
// PLAY (countdown, goal counting) -> OVER. A prescaler turns CLOCK_50 into
// one tick per game second; START pauses it. Goals come from a synchronised
// and debounced ball sensor and are limited to one per second. Sound requests
// are arbitrated by priority and each code is held for SOUND_HOLD cycles.
// Ports:
//   CLOCK_50     : clock
//   Clr          : asynchronous active-low reset
//   START        : run/pause level from the player switch
//   SENSOR       : raw asynchronous active-low ball sensor
//   TIMER        : seconds remaining
//   GOAL         : accepted goals (saturates at 63)
//   SOUND_SELECT : sound code to the audio block
//   STATE        : current FSM state
//   GAME_OVER    : high while in OVER
// -----------------------------------------------------------------------------
module game_controller
  import game_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int GAME_SECS  = 60,
  parameter int INTRO_SECS = 3,
  parameter int DEB_CYC    = 500000,
  parameter int SOUND_HOLD = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       Clr,
  input  logic       START,
  input  logic       SENSOR,
  output logic [5:0] TIMER,
  output logic [5:0] GOAL,
  output logic [3:0] SOUND_SELECT,
  output logic [1:0] STATE,
  output logic       GAME_OVER
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam int HW = (SOUND_HOLD > 1) ? $clog2(SOUND_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(SOUND_HOLD - 1);
  localparam logic [5:0] SECS_INIT  = 6'(GAME_SECS);
  localparam logic [5:0] INTRO_LAST = 6'(INTRO_SECS - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_game_over;
  logic [PW-1:0] r_pre;
  logic [5:0]    r_intro;
  logic [5:0]    r_timer;
  logic [5:0]    r_goal;
  logic [5:0]    r_last;
  logic [3:0]    r_sound;
  logic [HW-1:0] r_hold;
  logic          r_s1;
  logic          r_s2;
  logic          w_hit;
  logic          w_run;
  logic          w_tick;
  logic          w_accept;
  logic          w_enter_intro;
  logic          w_enter_over;
  logic [3:0]    w_req;

  // Two-flop synchroniser for the raw sensor; resets to the idle-high level.
  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= SENSOR;
      r_s2 <= r_s1;
    end
  end

  sensor_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .CLOCK_50 (CLOCK_50),
    .Clr      (Clr),
    .in       (r_s2),
    .hit      (w_hit)
  );

  assign w_run    = ((r_state == ST_INTRO) || (r_state == ST_PLAY)) && START;
  assign w_tick   = w_run && (r_pre == PRE_MAX);
  // r_timer is the pre-tick value, so a hit on the final tick still sees 1.
  assign w_accept = w_hit && (r_state == ST_PLAY) && (r_timer != 6'd0) && (r_timer < r_last);
  assign w_enter_intro = (r_state == ST_IDLE) && (w_next == ST_INTRO);
  assign w_enter_over  = (r_state == ST_PLAY) && (w_next == ST_OVER);

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (START) w_next = ST_INTRO; else w_next = ST_IDLE;
      ST_INTRO: if (w_tick && (r_intro == INTRO_LAST)) w_next = ST_PLAY; else w_next = ST_INTRO;
      ST_PLAY:  if (w_tick && (r_timer == 6'd1)) w_next = ST_OVER; else w_next = ST_PLAY;
      ST_OVER:  if (!START) w_next = ST_IDLE; else w_next = ST_OVER;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Highest-priority sound request raised this cycle.
  always_comb begin
    w_req = SND_OFF;
    if (w_enter_over) begin
      w_req = SND_END;
    end else if (w_accept) begin
      w_req = SND_GOAL;
    end else if (w_enter_intro) begin
      w_req = SND_START;
    end else begin
      w_req = SND_OFF;
    end
  end

  // State register and registered GAME_OVER flag.
  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      r_state     <= ST_IDLE;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_game_over <= (w_next == ST_OVER);
    end
  end

  // Second prescaler and intro-second counter; both restart on any state change.
  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      r_pre   <= {PW{1'b0}};
      r_intro <= 6'd0;
    end else if (w_next != r_state) begin
      r_pre   <= {PW{1'b0}};
      r_intro <= 6'd0;
    end else if (w_tick) begin
      r_pre <= {PW{1'b0}};
      if (r_state == ST_INTRO) r_intro <= r_intro + 6'd1;
    end else if (w_run) begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Countdown, goal counter and the time of the last accepted goal.
  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      r_timer <= SECS_INIT;
      r_goal  <= 6'd0;
      r_last  <= SECS_INIT;
    end else if (w_enter_intro) begin
      r_timer <= SECS_INIT;
      r_goal  <= 6'd0;
      r_last  <= SECS_INIT;
    end else begin
      if (w_tick && (r_state == ST_PLAY)) r_timer <= r_timer - 6'd1;
      if (w_accept) begin
        if (r_goal != 6'd63) r_goal <= r_goal + 6'd1;
        r_last <= r_timer;
      end
    end
  end

  // Sound arbitration and hold timer; equal priority restarts the hold.
  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      r_sound <= SND_OFF;
      r_hold  <= {HW{1'b0}};
    end else if ((w_req != SND_OFF) && (snd_prio(w_req) >= snd_prio(r_sound))) begin
      r_sound <= w_req;
      r_hold  <= {HW{1'b0}};
    end else if (r_sound != SND_OFF) begin
      if (r_hold == HOLD_MAX) begin
        r_sound <= SND_OFF;
        r_hold  <= {HW{1'b0}};
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign TIMER        = r_timer;
  assign GOAL         = r_goal;
  assign SOUND_SELECT = r_sound;
  assign STATE        = r_state;
  assign GAME_OVER    = r_game_over;

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
// Directed bench for game_controller with CLK_HZ=10, GAME_SECS=5,
// INTRO_SECS=2, DEB_CYC=4, SOUND_HOLD=8. Inputs change and outputs are
// sampled on the falling edge. Cycle numbers in comments count rising edges
// from the edge that first sees START=1 in IDLE (edge 1 enters INTRO).
// -----------------------------------------------------------------------------
module tb_game_controller;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic       sensor;
  logic [5:0] timer;
  logic [5:0] goal;
  logic [3:0] snd;
  logic [1:0] state;
  logic       game_over;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] chatter = 8'b1001_1010;  // applied LSB first: 0,1,0,1,1,0,0,1

  always #5 clk = ~clk;

  game_controller #(
    .CLK_HZ(10), .GAME_SECS(5), .INTRO_SECS(2), .DEB_CYC(4), .SOUND_HOLD(8)
  ) dut (
    .CLOCK_50     (clk),
    .Clr          (clr_n),
    .START        (start),
    .SENSOR       (sensor),
    .TIMER        (timer),
    .GOAL         (goal),
    .SOUND_SELECT (snd),
    .STATE        (state),
    .GAME_OVER    (game_over)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic check_all(input string tag, input int st, input int tm, input int gl,
                           input int sd, input int go);
    check({tag, ".state"},     32'(state),     32'(st));
    check({tag, ".timer"},     32'(timer),     32'(tm));
    check({tag, ".goal"},      32'(goal),      32'(gl));
    check({tag, ".sound"},     32'(snd),       32'(sd));
    check({tag, ".game_over"}, 32'(game_over), 32'(go));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clr_n  = 1'b0;
    start  = 1'b0;
    sensor = 1'b1;
    cyc(3);
    check_all("reset", 0, 5, 0, 0, 0);
    clr_n = 1'b1;
    cyc(10);
    check_all("idle", 0, 5, 0, 0, 0);

    // ---- Round 1: start sound, intro length, full countdown, OVER ----
    start = 1'b1;
    cyc(1);                                   // after edge 1
    check_all("intro_entry", 1, 5, 0, 10, 0);
    cyc(7);                                   // edge 8: last START-sound cycle
    check("start_snd_held", 32'(snd), 32'd10);
    cyc(1);                                   // edge 9
    check("start_snd_off", 32'(snd), 32'd0);
    cyc(11);                                  // edge 20
    check("intro_edge20", 32'(state), 32'd1);
    cyc(1);                                   // edge 21
    check_all("play_entry", 2, 5, 0, 0, 0);
    for (int s = 4; s >= 1; s--) begin        // ticks at edges 31,41,51,61
      cyc(10);
      check("countdown", 32'(timer), 32'(s));
    end
    cyc(9);                                   // edge 70
    check("pre_final_state", 32'(state), 32'd2);
    cyc(1);                                   // edge 71
    check_all("over_entry", 3, 0, 0, 12, 1);
    start = 1'b0;
    cyc(1);
    check_all("over_to_idle", 0, 0, 0, 12, 0);
    cyc(10);

    // ---- Round 2: goal acceptance, bounce, final-tick collision ----
    start = 1'b1;
    cyc(21);
    check_all("r2_play", 2, 5, 0, 0, 0);
    sensor = 1'b0; cyc(2); sensor = 1'b1; cyc(8);   // hit judged at edge 25, TIMER=5
    check("t5_hit_goal", 32'(goal), 32'd0);
    check("t5_hit_sound", 32'(snd), 32'd0);
    check("t5_timer_now4", 32'(timer), 32'd4);
    sensor = 1'b0; cyc(2); sensor = 1'b1; cyc(2);   // hit judged at edge 35, TIMER=4
    check("t4_goal", 32'(goal), 32'd1);
    check("t4_sound", 32'(snd), 32'd15);
    check("t4_timer", 32'(timer), 32'd4);
    sensor = 1'b0; cyc(2); sensor = 1'b1; cyc(3);   // second pulse, same second
    check("t4_second_goal", 32'(goal), 32'd1);
    check("t4_second_timer", 32'(timer), 32'd4);
    cyc(3);                                         // edge 43: detector re-armed
    for (int i = 0; i < 8; i++) begin
      sensor = chatter[i];
      cyc(1);
    end
    sensor = 1'b1;
    cyc(4);                                         // edge 55
    check("bounce_goal", 32'(goal), 32'd2);
    check("bounce_timer", 32'(timer), 32'd2);
    cyc(6);                                         // edge 61
    check("t1_timer", 32'(timer), 32'd1);
    cyc(6);                                         // edge 67
    sensor = 1'b0; cyc(2); sensor = 1'b1; cyc(1);   // hit pulse lands on edge 71
    check("collision_pre_goal", 32'(goal), 32'd2);
    cyc(1);
    check_all("collision", 3, 0, 3, 12, 1);
    start = 1'b0;
    cyc(1);
    check_all("r2_idle_hold", 0, 0, 3, 12, 0);
    cyc(10);

    // ---- Round 3: pause, then asynchronous reset mid-PLAY ----
    start = 1'b1;
    cyc(1);
    check_all("r3_intro", 1, 5, 0, 10, 0);
    cyc(32);                                        // edge 33
    check("r3_play_state", 32'(state), 32'd2);
    check("r3_timer4", 32'(timer), 32'd4);
    start = 1'b0;
    cyc(30);                                        // edge 63
    check("pause_timer", 32'(timer), 32'd4);
    check("pause_state", 32'(state), 32'd2);
    start = 1'b1;
    cyc(7);                                         // edge 70
    check("resume_pre_tick", 32'(timer), 32'd4);
    cyc(1);                                         // edge 71
    check("resume_tick", 32'(timer), 32'd3);
    sensor = 1'b0; cyc(2); sensor = 1'b1; cyc(2);   // goal at edge 75
    check("r3_goal", 32'(goal), 32'd1);
    check("r3_sound", 32'(snd), 32'd15);
    #2 clr_n = 1'b0;
    #1 check_all("async_reset", 0, 5, 0, 0, 0);
    cyc(4);
    start = 1'b0;
    cyc(1);
    clr_n = 1'b1;
    cyc(15);
    check_all("post_release", 0, 5, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
